// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR stream checksum block.
// Optional build macro: XOR_ROT_EN (rotating-XOR accumulation).
package xor_pkg;

    // Widest lane and most lanes the helper functions support.
    localparam int XW = 64;
    localparam int XL = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    // XOR together `lanes` lanes of `width` bits each (lane 0 = LSBs).
    function automatic logic [XW-1:0] fold_lanes(input logic [XW*XL-1:0] data,
                                                 input int width,
                                                 input int lanes);
        logic [XW-1:0] r;
        logic [9:0]    idx;
        r = '0;
        for (int l = 0; l < XL; l++) begin
            for (int b = 0; b < XW; b++) begin
                if (l < lanes && b < width) begin
                    idx  = 10'(l * width + b);
                    r[b] = r[b] ^ data[idx];
                end
            end
        end
        return r;
    endfunction

    // Rotate the low `width` bits of v left by one; bits above width stay 0.
    function automatic logic [XW-1:0] rotl1(input logic [XW-1:0] v,
                                            input int width);
        logic [XW-1:0] r;
        logic [5:0]    msb;
        msb  = 6'(width - 1);
        r    = '0;
        r[0] = v[msb];
        for (int i = 1; i < XW; i++) begin
            if (i < width) r[i] = v[i-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/xor_lane_fold.sv
// Combinational LANES-to-1 XOR tree; one reduction column per output bit.
module xor_lane_fold #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic [LANES-1:0][WIDTH-1:0] data,
    output logic [WIDTH-1:0]            fold
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [LANES-1:0] col;
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign col[l] = data[l][b];
        end
        assign fold[b] = ^col;
    end

endmodule

// File: rtl/xor_stream_checksum.sv
// Per-frame XOR checksum over LANES x WIDTH beats with valid/ready on both
// sides. Result is registered one cycle after the last beat is accepted.
// Optional build macro: XOR_ROT_EN -- non-first beats fold into rotl(acc,1).
module xor_stream_checksum
    import xor_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 2,
    parameter int MAX_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LANES*WIDTH-1:0]         in_data,
    input  logic                           in_valid,
    input  logic                           in_first,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               out_sum,
    output logic                           out_parity,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
    output logic                           out_err,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_nx;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_nx;
    logic             err_q, err_d, err_nx;
    logic [WIDTH-1:0] fold;
    logic [WIDTH-1:0] acc_base;
    logic [CW-1:0]    cnt_sat;
    logic             accept;
    logic             done;

    xor_lane_fold #(
        .WIDTH(WIDTH),
        .LANES(LANES)
    ) u_fold (
        .data(in_data),
        .fold(fold)
    );

    // A pending result blocks input only while it is not being consumed.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign done     = accept && in_last;

`ifdef XOR_ROT_EN
    logic [XW-1:0] rot_full;
    assign rot_full = rotl1(XW'(acc_q), WIDTH);
    assign acc_base = rot_full[WIDTH-1:0];
`else
    assign acc_base = acc_q;
`endif

    assign cnt_sat = (cnt_q == CW'(MAX_BEATS)) ? cnt_q : cnt_q + CW'(1);

    // Frame state register; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next frame state: *_nx is the post-beat value, *_d clears on frame end.
    always_comb begin
        state_d = state_q;
        acc_nx  = acc_q;
        cnt_nx  = cnt_q;
        err_nx  = err_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    acc_nx  = fold;
                    cnt_nx  = CW'(1);
                    err_nx  = !in_first;
                    state_d = ACC;
                end
                ACC: begin
                    if (in_first) begin
                        // Restart: the unfinished frame is dropped and flagged.
                        acc_nx = fold;
                        cnt_nx = CW'(1);
                        err_nx = 1'b1;
                    end else begin
                        acc_nx = acc_base ^ fold;
                        cnt_nx = cnt_sat;
                        err_nx = err_q || (cnt_q == CW'(MAX_BEATS));
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        acc_d = acc_nx;
        cnt_d = cnt_nx;
        err_d = err_nx;
        if (done) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    // Result register: load on frame end, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_parity <= 1'b0;
            out_beats  <= '0;
            out_err    <= 1'b0;
        end else if (done) begin
            out_valid  <= 1'b1;
            out_sum    <= acc_nx;
            out_parity <= ^acc_nx;
            out_beats  <= cnt_nx;
            out_err    <= err_nx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Self-checking bench for xor_stream_checksum (WIDTH=8, LANES=2) with a
// second instance at MAX_BEATS=4 for saturation / overlong checks.
module tb_xor_stream_checksum;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid, in_first, in_last, out_ready;

    logic        in_ready, out_parity, out_err, out_valid;
    logic [7:0]  out_sum;
    logic [4:0]  out_beats;

    logic        in_ready4, out_parity4, out_err4, out_valid4;
    logic [7:0]  out_sum4;
    logic [2:0]  out_beats4;

    int errors = 0;
    int checks = 0;

    logic [15:0] fq_d[$];
    bit          fq_f[$];

    always #5 clk = ~clk;

    xor_stream_checksum #(.WIDTH(8), .LANES(2), .MAX_BEATS(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .in_ready(in_ready),
        .out_sum(out_sum), .out_parity(out_parity), .out_beats(out_beats),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    xor_stream_checksum #(.WIDTH(8), .LANES(2), .MAX_BEATS(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .in_ready(in_ready4),
        .out_sum(out_sum4), .out_parity(out_parity4), .out_beats(out_beats4),
        .out_err(out_err4), .out_valid(out_valid4), .out_ready(out_ready)
    );

    // Reference: result of the beat list in fq_d/fq_f, derived from the frame
    // as a whole -- checksum covers the beats from the last first-marker on.
    function automatic void model(input int maxb, output logic [7:0] sum,
                                  output int beats, output bit err);
        int start = 0;
        int n     = fq_d.size();
        logic [15:0] w;
        logic [7:0]  f;
        err = !fq_f[0];
        for (int i = 1; i < n; i++) if (fq_f[i]) begin start = i; err = 1; end
        sum = 8'h00;
        for (int i = start; i < n; i++) begin
            w = fq_d[i];
            f = w[7:0] ^ w[15:8];
`ifdef XOR_ROT_EN
            sum = (i == start) ? f : ({sum[6:0], sum[7]} ^ f);
`else
            sum = sum ^ f;
`endif
        end
        beats = (n - start > maxb) ? maxb : n - start;
        if (n - start > maxb) err = 1;
    endfunction

    task automatic send_beat(input logic [15:0] d, input bit f, input bit l);
        int t = 0;
        @(negedge clk);
        in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                errors++; checks++;
                $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Send the queued frame (last on final beat) and check both instances.
    task automatic run_frame(input string name);
        logic [7:0] es;
        int eb;
        bit ee;
        for (int i = 0; i < fq_d.size(); i++)
            send_beat(fq_d[i], fq_f[i], i == fq_d.size() - 1);
        model(16, es, eb, ee);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== es || out_parity !== ^es ||
            out_beats !== 5'(eb) || out_err !== ee) begin
            errors++;
            $display("FAIL %s got v=%0b sum=%h par=%0b beats=%0d err=%0b required v=1 sum=%h par=%0b beats=%0d err=%0b",
                     name, out_valid, out_sum, out_parity, out_beats, out_err, es, ^es, eb, ee);
        end
        model(4, es, eb, ee);
        checks++;
        if (out_valid4 !== 1'b1 || out_sum4 !== es || out_parity4 !== ^es ||
            out_beats4 !== 3'(eb) || out_err4 !== ee) begin
            errors++;
            $display("FAIL %s_max4 got v=%0b sum=%h beats=%0d err=%0b required v=1 sum=%h beats=%0d err=%0b",
                     name, out_valid4, out_sum4, out_beats4, out_err4, es, eb, ee);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_first = 0; in_last = 0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_sum !== 8'h00 || out_err !== 0 ||
            out_beats !== 5'd0 || out_parity !== 0) begin
            errors++;
            $display("FAIL reset got v=%0b rdy=%0b sum=%h err=%0b beats=%0d par=%0b required 0 1 00 0 0 0",
                     out_valid, in_ready, out_sum, out_err, out_beats, out_parity);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single();
        fq_d = '{16'hA55A}; fq_f = '{1'b1};
        run_frame("single");
        checks++;
        if (out_sum !== 8'hFF || out_parity !== 1'b0 || out_beats !== 5'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL single_const got sum=%h par=%0b beats=%0d err=%0b required ff 0 1 0",
                     out_sum, out_parity, out_beats, out_err);
        end
    endtask

    task automatic test_three();
        logic [7:0] exp;
`ifdef XOR_ROT_EN
        exp = 8'h24;
`else
        exp = 8'h3F;
`endif
        fq_d = '{16'h0102, 16'h0408, 16'h1020}; fq_f = '{1'b1, 1'b0, 1'b0};
        run_frame("three");
        checks++;
        if (out_sum !== exp || out_parity !== 1'b0 || out_beats !== 5'd3) begin
            errors++;
            $display("FAIL three_const got sum=%h par=%0b beats=%0d required %h 0 3",
                     out_sum, out_parity, out_beats, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s;
        logic [4:0] b;
        fq_d = '{16'h3C5A, 16'h7700}; fq_f = '{1'b1, 1'b0};
        run_frame("bp_frame");
        out_ready = 1'b0;
        s = out_sum; b = out_beats;
        // Offer a beat during the stall; it must not be taken.
        @(negedge clk);
        in_data = 16'h00FF; in_first = 1; in_last = 1; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1 || out_sum !== s || out_beats !== b || in_ready !== 0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%0b sum=%h beats=%0d rdy=%0b required 1 %h %0d 0",
                         i, out_valid, out_sum, out_beats, in_ready, s, b);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1) begin
            errors++;
            $display("FAIL bp_release in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || out_sum !== 8'hFF || out_beats !== 5'd1 || out_err !== 0) begin
            errors++;
            $display("FAIL bp_newframe got v=%0b sum=%h beats=%0d err=%0b required 1 ff 1 0",
                     out_valid, out_sum, out_beats, out_err);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL bp_consumed out_valid=%0b required=0", out_valid);
        end
    endtask

    task automatic test_restart();
        logic [15:0] d2 = 16'($urandom);
        fq_d = '{16'($urandom), d2, 16'h0303}; fq_f = '{1'b1, 1'b1, 1'b0};
        run_frame("restart");
        checks++;
        if (out_beats !== 5'd2 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL restart_const got beats=%0d err=%0b required 2 1", out_beats, out_err);
        end
    endtask

    task automatic test_no_first();
        fq_d = '{16'h1234, 16'h5678}; fq_f = '{1'b0, 1'b0};
        run_frame("no_first");
        checks++;
        if (out_err !== 1'b1) begin
            errors++;
            $display("FAIL no_first_err got err=%0b required 1", out_err);
        end
    endtask

    task automatic test_overlong();
        fq_d = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        fq_f = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_frame("overlong5");
        checks++;
        if (out_beats4 !== 3'd4 || out_err4 !== 1'b1 || out_beats !== 5'd5 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL overlong_const got beats4=%0d err4=%0b beats=%0d err=%0b required 4 1 5 0",
                     out_beats4, out_err4, out_beats, out_err);
        end
`ifndef XOR_ROT_EN
        checks++;
        if (out_sum4 !== 8'h01) begin
            errors++;
            $display("FAIL overlong_sum got %h required 01", out_sum4);
        end
`endif
        fq_d.delete(); fq_f.delete();
        for (int i = 0; i < 18; i++) begin
            fq_d.push_back(16'($urandom)); fq_f.push_back(i == 0);
        end
        run_frame("overlong18");
    endtask

    task automatic test_reset_midframe();
        send_beat(16'hBEEF, 1, 0);
        send_beat(16'hCAFE, 0, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 0 || out_beats !== 5'd0) begin
            errors++;
            $display("FAIL midreset got v=%0b beats=%0d required 0 0", out_valid, out_beats);
        end
        @(negedge clk); rst = 1'b0;
        fq_d = '{16'h8001}; fq_f = '{1'b1};
        run_frame("after_reset");
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 25; k++) begin
            fq_d.delete(); fq_f.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                fq_d.push_back(16'($urandom));
                fq_f.push_back(i == 0 ? ($urandom % 8 != 0) : ($urandom % 12 == 0));
            end
            run_frame($sformatf("random%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_backpressure();
        test_restart();
        test_no_first();
        test_overlong();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
